// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared types and default sizes for the single-port RAM arbiter.
//   RAM_DATA_W / RAM_ADDR_W / RAM_DEPTH : default RAM geometry
//   state_e : controller FSM states
//   src_e   : requester identity (A or B)
//   cmd_t   : latched command {we, addr, wdata}
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR         = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_CAPTURE = 3'd3,
    ERR        = 3'd4
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// lines and the last_served register; last_served advances only when the
// grant is actually taken (i_en high).
//   clk, rst          : clock, synchronous active-high reset
//   i_req_a, i_req_b  : request lines
//   i_en              : grant is consumed this cycle
//   o_gnt_a, o_gnt_b  : one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_en,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  src_e r_last_served;

  // Grant selection: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (i_req_a && i_req_b) begin
      if (r_last_served == SRC_B) begin
        o_gnt_a = 1'b1;
      end else begin
        o_gnt_b = 1'b1;
      end
    end else if (i_req_a) begin
      o_gnt_a = 1'b1;
    end else if (i_req_b) begin
      o_gnt_b = 1'b1;
    end else begin
      o_gnt_a = 1'b0;
      o_gnt_b = 1'b0;
    end
  end

  // last_served register; resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_served <= SRC_B;
    end else if (i_en && o_gnt_a) begin
      r_last_served <= SRC_A;
    end else if (i_en && o_gnt_b) begin
      r_last_served <= SRC_B;
    end else begin
      r_last_served <= r_last_served;
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sp_arbiter
// Shares one single-port RAM (registered read, bidirectional data bus)
// between requesters A and B with round-robin arbitration.
//   clk, rst                      : clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     : requester A command (held until a_gnt)
//   a_gnt/a_done/a_err/a_rdata    : requester A handshake and read data
//   b_*                           : same for requester B
//   ram_read_en/ram_write_en      : RAM strobes (registered, never both high)
//   ram_addr                      : RAM address (the latched command address)
//   ram_data                      : RAM data bus; driven only in WR
// Write: accept -> WR -> IDLE(done). Read: accept -> RD_ISSUE -> RD_CAPTURE
// -> IDLE(done). Out-of-range: accept -> ERR -> IDLE(done+err).
// The command struct uses the package widths, so DATA_W/ADDR_W must equal
// the package defaults.
// ---------------------------------------------------------------------------
module ram_sp_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  state_e            w_next_state;
  cmd_t              r_cmd;
  cmd_t              w_sel_cmd;
  src_e              r_owner;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_idle;
  logic              w_accept;
  logic              w_sel_oor;
  logic              w_finish;
  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_a_done;
  logic              r_b_done;
  logic              r_a_err;
  logic              r_b_err;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_read_en;
  logic              r_write_en;
  logic              r_bus_oe;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (a_req || b_req);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req_a (a_req),
    .i_req_b (b_req),
    .i_en    (w_idle),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  // Command of the current arbitration winner.
  always_comb begin
    w_sel_cmd = '0;
    if (w_gnt_b) begin
      w_sel_cmd.we    = b_we;
      w_sel_cmd.addr  = b_addr;
      w_sel_cmd.wdata = b_wdata;
    end else begin
      w_sel_cmd.we    = a_we;
      w_sel_cmd.addr  = a_addr;
      w_sel_cmd.wdata = a_wdata;
    end
  end

  assign w_sel_oor = ({1'b0, w_sel_cmd.addr} >= LP_DEPTH);

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_oor) begin
            w_next_state = ERR;
          end else if (w_sel_cmd.we) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD_ISSUE;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WR:         w_next_state = IDLE;
      RD_ISSUE:   w_next_state = RD_CAPTURE;
      RD_CAPTURE: w_next_state = IDLE;
      ERR:        w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Every access ends in exactly one of these states; done follows it.
  assign w_finish = (r_state == WR) || (r_state == RD_CAPTURE) || (r_state == ERR);

  // State register and command latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_owner <= SRC_A;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cmd   <= w_sel_cmd;
        r_owner <= w_gnt_b ? SRC_B : SRC_A;
      end else begin
        r_cmd   <= r_cmd;
        r_owner <= r_owner;
      end
    end
  end

  // RAM strobes and bus enable, registered from the next state so they
  // line up with the state they belong to and never see req directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_bus_oe   <= 1'b0;
    end else begin
      r_write_en <= (w_next_state == WR);
      r_bus_oe   <= (w_next_state == WR);
      r_read_en  <= (w_next_state == RD_ISSUE) || (w_next_state == RD_CAPTURE);
    end
  end

  // Grant, done and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_a_err  <= 1'b0;
      r_b_err  <= 1'b0;
    end else begin
      r_a_gnt  <= w_accept && w_gnt_a;
      r_b_gnt  <= w_accept && w_gnt_b;
      r_a_done <= w_finish && (r_owner == SRC_A);
      r_b_done <= w_finish && (r_owner == SRC_B);
      r_a_err  <= (r_state == ERR) && (r_owner == SRC_A);
      r_b_err  <= (r_state == ERR) && (r_owner == SRC_B);
    end
  end

  // Read data capture; each requester keeps its last read value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (r_state == RD_CAPTURE && r_owner == SRC_A) begin
        r_a_rdata <= ram_data;
      end else if (r_state == ERR && r_owner == SRC_A) begin
        r_a_rdata <= '0;
      end else begin
        r_a_rdata <= r_a_rdata;
      end
      if (r_state == RD_CAPTURE && r_owner == SRC_B) begin
        r_b_rdata <= ram_data;
      end else if (r_state == ERR && r_owner == SRC_B) begin
        r_b_rdata <= '0;
      end else begin
        r_b_rdata <= r_b_rdata;
      end
    end
  end

  assign a_gnt        = r_a_gnt;
  assign b_gnt        = r_b_gnt;
  assign a_done       = r_a_done;
  assign b_done       = r_b_done;
  assign a_err        = r_a_err;
  assign b_err        = r_b_err;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign ram_read_en  = r_read_en;
  assign ram_write_en = r_write_en;
  assign ram_addr     = r_cmd.addr;
  assign ram_data     = r_bus_oe ? r_cmd.wdata : {DATA_W{1'bz}};

endmodule
